// File: rtl/ddr_pkg.sv
// Shared FSM states, MIG command codes and default widths for the DDR burst arbiter.
package ddr_pkg;
    typedef enum logic [1:0] {IDLE, WRITE, READ, RD_DRAIN} state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int DEF_DATA_W    = 128;
    localparam int DEF_ADDR_W    = 28;
    localparam int DEF_ADDR_STEP = 8;
endpackage

// File: rtl/ddr_addr_gen.sv
// Circular frame pointer: base plus an offset that steps per beat and reloads to zero at the frame end.
module ddr_addr_gen #(
    parameter int ADDR_W     = 28,
    parameter int STEP       = 8,
    parameter int SPAN_BEATS = 32400
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              adv_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              wrap_o
);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] LIMIT  = ADDR_W'(SPAN_BEATS * STEP);

    logic [ADDR_W-1:0] off_q, off_d, off_inc;

    always_comb begin
        off_inc = off_q + STEP_A;
        wrap_o  = adv_i && (off_inc == LIMIT);
        off_d   = off_q;
        if (adv_i) begin
            off_d = wrap_o ? '0 : off_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    // Offset is kept separate from the base so a bank switch never disturbs the position.
    assign ptr_o = base_i + off_q;
endmodule

// File: rtl/ddr_burst_arb.sv
// MIG app-interface master arbitrating one write and one read image channel in fixed bursts.
// Optional ping-pong frame buffering is enabled with the macro DDR_PINGPONG_EN.
module ddr_burst_arb
    import ddr_pkg::*;
#(
    parameter int          DATA_W      = DEF_DATA_W,
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          BURST_LEN   = 64,
    parameter int          ADDR_STEP   = DEF_ADDR_STEP,
    parameter int          FRAME_BEATS = 32400,
    parameter int unsigned WR_BASE     = 0,
    parameter int unsigned BANK_OFFSET = 32'h0040_0000
) (
    input  logic              ui_clk,
    input  logic              ui_rst_n,
    input  logic              init_calib_complete,
    input  logic              wr_req,
    output logic              wr_data_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_vld,
    output logic              frame_done,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid
`ifdef DDR_PINGPONG_EN
    ,
    output logic              wr_bank
`endif
);
    localparam int                CNT_W  = $clog2(BURST_LEN + 2);
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL   = CNT_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] BANK_A = ADDR_W'(BANK_OFFSET);
    localparam logic [6:0]        QUIET  = 7'd64;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, ret_q, ret_d, ret_sum;
    logic              prio_wr_q, prio_wr_d;
    logic              full_q;
    logic [6:0]        quiet_q;
    logic              rd_open, rd_beat, rd_ok, rd_go;
    logic              rd_vld_q, frame_done_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_beat, rd_cmd, wr_wrap, rd_wrap, wr_sel, rd_sel;
    logic [ADDR_W-1:0] wr_base, rd_base, wr_ptr, rd_ptr;

`ifdef DDR_PINGPONG_EN
    logic wr_bank_q, rd_bank_q;

    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
        end else begin
            if (wr_wrap) wr_bank_q <= ~wr_bank_q;
            if (rd_wrap) rd_bank_q <= ~wr_bank_q;
        end
    end

    assign wr_sel  = wr_bank_q;
    assign rd_sel  = rd_bank_q;
    assign wr_bank = wr_bank_q;
    assign rd_ok   = full_q && (rd_bank_q != wr_bank_q);
`else
    logic unused_rd_wrap;
    assign unused_rd_wrap = rd_wrap;
    assign wr_sel = 1'b0;
    assign rd_sel = 1'b0;
    // Until a whole frame exists, equal pointers mean the reader has caught up with the writer.
    assign rd_ok  = full_q || (rd_ptr != wr_ptr);
`endif

    assign wr_base = BASE_A + (wr_sel ? BANK_A : '0);
    assign rd_base = BASE_A + (rd_sel ? BANK_A : '0);

    ddr_addr_gen #(.ADDR_W(ADDR_W), .STEP(ADDR_STEP), .SPAN_BEATS(FRAME_BEATS)) u_wr_ptr (
        .clk_i(ui_clk), .rst_ni(ui_rst_n), .base_i(wr_base), .adv_i(wr_beat),
        .ptr_o(wr_ptr), .wrap_o(wr_wrap)
    );

    ddr_addr_gen #(.ADDR_W(ADDR_W), .STEP(ADDR_STEP), .SPAN_BEATS(FRAME_BEATS)) u_rd_ptr (
        .clk_i(ui_clk), .rst_ni(ui_rst_n), .base_i(rd_base), .adv_i(rd_cmd),
        .ptr_o(rd_ptr), .wrap_o(rd_wrap)
    );

    assign rd_open = (quiet_q == QUIET);
    assign rd_beat = app_rd_data_valid && rd_open;
    assign ret_sum = ret_q + CNT_W'(rd_beat);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        prio_wr_d    = prio_wr_q;
        wr_beat      = 1'b0;
        rd_cmd       = 1'b0;
        wr_data_req  = 1'b0;
        app_en       = 1'b0;
        app_cmd      = CMD_WR;
        app_addr     = '0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        rd_go        = rd_req && rd_ok;
        case (state_q)
            IDLE: begin
                if (init_calib_complete) begin
                    if (wr_req && rd_go) begin
                        state_d   = prio_wr_q ? WRITE : READ;
                        prio_wr_d = ~prio_wr_q;
                    end else if (wr_req) begin
                        state_d = WRITE;
                    end else if (rd_go) begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (init_calib_complete) begin
                    app_en       = 1'b1;
                    app_wdf_wren = 1'b1;
                    app_addr     = wr_ptr;
                    app_wdf_data = wr_data;
                    wr_beat      = app_rdy && app_wdf_rdy;
                    wr_data_req  = wr_beat;
                    if (wr_beat) begin
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            READ: begin
                if (init_calib_complete) begin
                    app_en   = 1'b1;
                    app_cmd  = CMD_RD;
                    app_addr = rd_ptr;
                    rd_cmd   = app_rdy;
                    if (rd_cmd) begin
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = RD_DRAIN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            RD_DRAIN: begin
                if (ret_sum >= FULL) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ret_d = '0;
        if (state_q == READ || (state_q == RD_DRAIN && state_d == RD_DRAIN)) ret_d = ret_sum;
    end

    always_ff @(posedge ui_clk) begin
        if (!ui_rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ret_q        <= '0;
            prio_wr_q    <= 1'b1;
            full_q       <= 1'b0;
            quiet_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_data_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ret_q        <= ret_d;
            prio_wr_q    <= prio_wr_d;
            full_q       <= full_q | wr_wrap;
            quiet_q      <= rd_open ? quiet_q : quiet_q + 7'd1;
            rd_vld_q     <= rd_beat;
            rd_data_q    <= app_rd_data;
            frame_done_q <= wr_wrap;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_data_vld = rd_vld_q;
    assign frame_done  = frame_done_q;
    assign app_wdf_end = app_wdf_wren;
endmodule
